// File: rtl/rtype_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rtype_issue_ctrl
// Purpose  : Buffers RV64I R-type instruction words in a small FIFO, decodes
//            them into register numbers and an ALU code, holds the operands
//            for a settle period and then pulses regwrite for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rtype_issue_ctrl #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        halt,
    input  logic        zero_flag,
    output logic [4:0]  read_reg_num1,
    output logic [4:0]  read_reg_num2,
    output logic [4:0]  write_reg,
    output logic [3:0]  alu_control,
    output logic        regwrite,
    output logic        busy,
    output logic        illegal_instr,
    output logic        last_zero,
    output logic [31:0] retired_count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_exec = 2'd2;

    logic [31:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ready_en;
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_settle_cnt;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [4:0]         r_rd;
    logic [3:0]         r_alu;
    logic               r_legal;
    logic               r_last_zero;
    logic [31:0]        r_retired_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_head;
    logic [3:0]         w_dec_alu;
    logic               w_dec_legal;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = instr_valid & instr_ready;
    // Pops happen only where a new instruction may start: from IDLE, or
    // straight out of EXEC for back-to-back issue. Uses the pre-edge count,
    // so a word pushed into an empty FIFO is never popped on the same edge.
    assign w_pop   = ((r_state == c_idle) || (r_state == c_exec)) & ~w_empty & ~halt;
    assign w_head  = r_mem[r_rd_ptr];

    // Decode the FIFO head into an ALU code and a legality flag
    always_comb begin
        w_dec_alu   = 4'b0000;
        w_dec_legal = 1'b0;
        if (w_head[6:0] == 7'b0110011) begin
            case ({w_head[31:25], w_head[14:12]})
                10'b0000000_000: begin w_dec_alu = 4'b0010; w_dec_legal = 1'b1; end
                10'b0000000_001: begin w_dec_alu = 4'b0100; w_dec_legal = 1'b1; end
                10'b0000000_010: begin w_dec_alu = 4'b1000; w_dec_legal = 1'b1; end
                10'b0000000_011: begin w_dec_alu = 4'b1001; w_dec_legal = 1'b1; end
                10'b0000000_100: begin w_dec_alu = 4'b0011; w_dec_legal = 1'b1; end
                10'b0000000_101: begin w_dec_alu = 4'b0101; w_dec_legal = 1'b1; end
                10'b0000000_110: begin w_dec_alu = 4'b0001; w_dec_legal = 1'b1; end
                10'b0000000_111: begin w_dec_alu = 4'b0000; w_dec_legal = 1'b1; end
                10'b0100000_000: begin w_dec_alu = 4'b0110; w_dec_legal = 1'b1; end
                10'b0100000_101: begin w_dec_alu = 4'b0111; w_dec_legal = 1'b1; end
                default:         begin w_dec_alu = 4'b0000; w_dec_legal = 1'b0; end
            endcase
        end
    end

    // Instruction storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= instr;
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  w_next_state = w_pop ? c_load : c_idle;
            c_load:  w_next_state = (r_settle_cnt == 4'd0) ? c_exec : c_load;
            c_exec:  w_next_state = w_pop ? c_load : c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Operand latch on pop, settle countdown, and retirement bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rs1           <= '0;
            r_rs2           <= '0;
            r_rd            <= '0;
            r_alu           <= '0;
            r_legal         <= 1'b0;
            r_settle_cnt    <= '0;
            r_last_zero     <= 1'b0;
            r_retired_count <= '0;
        end else begin
            if ((r_state == c_exec) && r_legal) begin
                r_last_zero     <= zero_flag;
                r_retired_count <= r_retired_count + 32'd1;
            end
            if (w_pop) begin
                r_rs1        <= w_head[19:15];
                r_rs2        <= w_head[24:20];
                r_rd         <= w_head[11:7];
                r_alu        <= w_dec_alu;
                r_legal      <= w_dec_legal;
                r_settle_cnt <= 4'(SETTLE_CYCLES - 1);
            end else if ((r_state == c_load) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end
        end
    end

    // FSM outputs: write strobe and illegal pulse exist only in EXEC
    always_comb begin
        regwrite      = 1'b0;
        illegal_instr = 1'b0;
        if (r_state == c_exec) begin
            regwrite      = r_legal & (r_rd != 5'd0);
            illegal_instr = ~r_legal;
        end
    end

    assign instr_ready   = r_ready_en & ~w_full;
    assign busy          = (r_state != c_idle) | ~w_empty;
    assign read_reg_num1 = r_rs1;
    assign read_reg_num2 = r_rs2;
    assign write_reg     = r_rd;
    assign alu_control   = r_alu;
    assign last_zero     = r_last_zero;
    assign retired_count = r_retired_count;

endmodule
`default_nettype wire

// File: doc/rtype_issue_ctrl.md
Name: rtype_issue_ctrl

Overview:
- Sequencer in front of the 64-bit register-file/ALU datapath.
- Accepts RV64I R-type (OP, opcode 0110011) instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each instruction into register numbers and an ALU control code, and drives the datapath control inputs.
- Holds operands stable for a programmable ALU settle period, then pulses regwrite for one cycle.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, >=2).
- SETTLE_CYCLES, 1, cycles operands are held before the write cycle (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  FIFO can accept a word (= !full).
- halt  in  1  stop issuing new instructions; the in-flight instruction completes.
- zero_flag  in  1  from the datapath ALU.
- read_reg_num1  out  5  rs1 (instr[19:15]).
- read_reg_num2  out  5  rs2 (instr[24:20]).
- write_reg  out  5  rd (instr[11:7]).
- alu_control  out  4  decoded ALU operation.
- regwrite  out  1  datapath write enable.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- illegal_instr  out  1  one-cycle pulse for an undecodable word.
- last_zero  out  1  zero_flag captured on the last legal write cycle.
- retired_count  out  32  count of legal instructions completed; wraps.

Behaviour:
- Reset (async, immediate):
  - FSM to IDLE; FIFO empty.
  - All outputs 0, including regwrite. instr_ready rises on the first cycle after reset deasserts.
- Push: on a clock edge with instr_valid & instr_ready, write instr at the tail. No push when full; a word presented while full stays pending until accepted.
- FSM states are IDLE, LOAD, EXEC.
- IDLE:
  - If the FIFO is non-empty and !halt: pop the head, register rs1/rs2/rd/alu_control and the legal flag, load settle_cnt = SETTLE_CYCLES-1, go to LOAD.
- LOAD:
  - regwrite = 0; operand outputs stable.
  - settle_cnt decrements each cycle; when it reaches 0, go to EXEC.
- EXEC (exactly one cycle):
  - regwrite = legal & (rd != 0).
  - illegal_instr = !legal.
  - If legal: last_zero <= zero_flag, and retired_count += 1 at the end of the cycle (rd = 0 counts as retired, no write).
  - Next state: if FIFO non-empty & !halt, pop and go to LOAD (back-to-back issue); otherwise go to IDLE. Outputs hold their last values in IDLE.
- Timing:
  - Latency: word accepted at edge E0 → LOAD from E1 → EXEC at E1+SETTLE_CYCLES → datapath write at the following edge.
  - Throughput: 1 instruction per SETTLE_CYCLES+1 cycles.
- Push and pop on the same edge are both allowed; the count is unchanged. A push into an empty FIFO is not popped on that same edge.
- halt:
  - Sampled only at pop decisions; it never aborts LOAD/EXEC.
  - While halted, the FIFO still accepts words until full.
- Decode: legal requires opcode = 0110011.
  - funct7 = 0000000, by funct3:
    - 000 ADD → 0010
    - 001 SLL → 0100
    - 010 SLT → 1000
    - 011 SLTU → 1001
    - 100 XOR → 0011
    - 101 SRL → 0101
    - 110 OR → 0001
    - 111 AND → 0000
  - funct7 = 0100000, by funct3:
    - 000 SUB → 0110
    - 101 SRA → 0111
  - Any other combination is illegal. Illegal words still drive alu_control = 0000 and their field values.
- FIFO pointers wrap modulo DEPTH; occupancy counter has DEPTH+1 states. retired_count wraps from FFFFFFFF to 0.
- Reset during LOAD/EXEC abandons the instruction; no regwrite occurs.

Test Plan:
- Reset, then push ADD x3,x1,x2 (0x002081B3), SETTLE_CYCLES=1 → LOAD 1 cycle after the accept edge; EXEC next with read_reg_num1=1, read_reg_num2=2, write_reg=3, alu_control=0010, regwrite=1 for exactly 1 cycle; retired_count=1.
- Push SUB x5,x6,x7 (0x407302B3) with zero_flag=1 during EXEC → alu_control=0110, last_zero=1; with SETTLE_CYCLES=3, regwrite rises exactly 3 cycles after LOAD entry.
- Push 0x0000F033 (funct7=0, funct3=111, rd=0) → alu_control=0000, regwrite=0, illegal_instr=0, retired_count increments. Push 0x02208133 (funct7=0000001) → illegal_instr pulses 1 cycle, regwrite=0, count unchanged.
- Hold instr_valid=1 with DEPTH+2 distinct words, halt=1 → instr_ready=0 after DEPTH accepts. Release halt → all words issued in order, back-to-back every SETTLE_CYCLES+1 cycles, with simultaneous push/pop while draining.
- Assert reset mid-EXEC → regwrite drops asynchronously, FIFO empty, busy=0, retired_count=0.
- Preload retired_count to near wrap via 2^32-driven force → increments FFFFFFFF→0.
